// File: rtl/mem_align_sequencer.sv
// Splits MEM-stage loads/stores into aligned LW reads and SW/SB writes for datamemory.
// Optional macro MISALIGN_TRAP_EN: trap misaligned requests instead of splitting them.
module mem_align_sequencer #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     rd,
  output logic                  misalign_err,
  output logic                  dm_MemRead,
  output logic                  dm_MemWrite,
  output logic [DM_ADDRESS-1:0] dm_a,
  output logic [DATA_W-1:0]     dm_wd,
  output logic [2:0]            dm_Funct3,
  input  logic [DATA_W-1:0]     dm_rd
);
  localparam int WA = DM_ADDRESS - 2;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [2:0] {IDLE, LD_LO, LD_HI, ST_SEQ, RESP} state_t;
  state_t state, next_state;

  logic                  is_load_q;
  logic                  single_q;
  logic                  cross_q;
  logic [1:0]            k_q;
  logic [1:0]            klast_q;
  logic [2:0]            f3_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     lo_q;
  logic [DATA_W-1:0]     hi_q;

  logic       req_fire;
  logic       req_load;
  logic       req_store;
  logic       req_cross;
  logic       req_single;
  logic       req_trap;
  logic [2:0] req_size;
  logic [1:0] req_klast;
  logic [3:0] req_end;

  // Request decode; a request with both flags set is handled as a store.
  always_comb begin
    req_fire  = req_valid && (state == IDLE);
    req_store = MemWrite;
    req_load  = MemRead && !MemWrite;
    if (req_store) begin
      case (Funct3)
        3'b000:  begin req_size = 3'd1; req_klast = 2'd0; end
        3'b001:  begin req_size = 3'd2; req_klast = 2'd1; end
        default: begin req_size = 3'd4; req_klast = 2'd3; end
      endcase
    end else begin
      case (Funct3)
        3'b000, 3'b100: begin req_size = 3'd1; req_klast = 2'd0; end
        3'b001, 3'b101: begin req_size = 3'd2; req_klast = 2'd1; end
        default:        begin req_size = 3'd4; req_klast = 2'd3; end
      endcase
    end
    req_end    = {2'b00, addr[1:0]} + {1'b0, req_size};
    req_cross  = req_load && (req_end > 4'd4);
    req_single = req_store && (req_size == 3'd4) && (addr[1:0] == 2'b00);
`ifdef MISALIGN_TRAP_EN
    req_trap = (req_load || req_store) &&
               (((req_size == 3'd2) && addr[0]) ||
                ((req_size == 3'd4) && (addr[1:0] != 2'b00)));
`else
    req_trap = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_fire) begin
          if (req_trap)       next_state = RESP;
          else if (req_store) next_state = ST_SEQ;
          else if (req_load)  next_state = LD_LO;
          else                next_state = RESP;
        end
      end
      LD_LO:   next_state = cross_q ? LD_HI : RESP;
      LD_HI:   next_state = RESP;
      ST_SEQ:  if (k_q == klast_q) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture, read-word capture and byte-write counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_load_q <= 1'b0;
      single_q  <= 1'b0;
      cross_q   <= 1'b0;
      k_q       <= 2'd0;
      klast_q   <= 2'd0;
      f3_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      if (req_fire) begin
        is_load_q <= req_load && !req_trap;
        single_q  <= req_single;
        cross_q   <= req_cross;
        klast_q   <= req_single ? 2'd0 : req_klast;
        k_q       <= 2'd0;
        f3_q      <= Funct3;
        addr_q    <= addr;
        wdata_q   <= wdata;
      end
      if (state == LD_LO)  lo_q <= dm_rd;
      if (state == LD_HI)  hi_q <= dm_rd;
      if (state == ST_SEQ) k_q  <= k_q + 2'd1;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset)         err_q <= 1'b0;
    else if (req_fire) err_q <= req_trap;
  end
`endif

  logic [WA-1:0]         word_q;
  logic [DM_ADDRESS-1:0] byte_a;
  logic [7:0]            st_byte;
  logic [DATA_W-1:0]     ld_shift;
  logic [DATA_W-1:0]     ld_ext;

  // All dm_* outputs depend only on state and captured registers.
  always_comb begin
    word_q   = addr_q[DM_ADDRESS-1:2];
    byte_a   = addr_q + DM_ADDRESS'(k_q);
    st_byte  = wdata_q[{k_q, 3'b000} +: 8];
    ld_shift = DATA_W'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase

    req_ready   = (state == IDLE);
    resp_valid  = 1'b0;
    rd          = '0;
    dm_MemRead  = 1'b0;
    dm_MemWrite = 1'b0;
    dm_a        = '0;
    dm_wd       = '0;
    dm_Funct3   = F3_SW;
    case (state)
      LD_LO: begin
        dm_MemRead = 1'b1;
        dm_a       = {word_q, 2'b00};
      end
      LD_HI: begin
        dm_MemRead = 1'b1;
        dm_a       = {word_q + WA'(1), 2'b00};
      end
      ST_SEQ: begin
        dm_MemWrite = 1'b1;
        if (single_q) begin
          dm_a  = addr_q;
          dm_wd = wdata_q;
        end else begin
          dm_Funct3 = F3_SB;
          dm_a      = byte_a;
          dm_wd     = DATA_W'(st_byte) << {byte_a[1:0], 3'b000};
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (is_load_q) rd = ld_ext;
      end
      default: ;
    endcase

`ifdef MISALIGN_TRAP_EN
    misalign_err = (state == RESP) && err_q;
`else
    misalign_err = 1'b0;
`endif
  end

endmodule

// File: doc/mem_align_sequencer.md
Name: mem_align_sequencer

Overview:
- Sits directly upstream of datamemory, between the MEM-stage request (ALU address, store data, Funct3, MemRead/MemWrite) and the data memory port.
- Splits every access into accesses datamemory handles correctly:
  - Loads become aligned word reads (LW); extraction, sign-extension and zero-extension are done here.
  - Stores become one aligned SW or a sequence of byte writes (SB).
- Adds full misaligned load/store support, including word-crossing, with a valid/ready handshake that the pipeline uses as a stall.

Parameters:
- DM_ADDRESS, 9, byte-address width of the data memory port.
- DATA_W, 32, data width. Only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle; request accepted when req_valid && req_ready
- MemRead  in  1  load request
- MemWrite  in  1  store request
- Funct3  in  3  instr[14:12]
- addr  in  DM_ADDRESS  byte address
- wdata  in  DATA_W  store data
- resp_valid  out  1  one-cycle completion pulse
- rd  out  DATA_W  load result, valid while resp_valid
- misalign_err  out  1  misalignment trap flag, valid with resp_valid
- dm_MemRead  out  1  to datamemory MemRead
- dm_MemWrite  out  1  to datamemory MemWrite
- dm_a  out  DM_ADDRESS  to datamemory a
- dm_wd  out  DATA_W  to datamemory wd
- dm_Funct3  out  3  to datamemory Funct3
- dm_rd  in  DATA_W  from datamemory rd; valid in the same cycle dm_MemRead is high

Behaviour:
- Reset, and state at reset release:
  - State IDLE, req_ready=1.
  - resp_valid=0, misalign_err=0, rd=0.
  - dm_MemRead=0, dm_MemWrite=0, dm_a=0, dm_wd=0, dm_Funct3=3'b010.
- Output timing:
  - All dm_* outputs come from registered state only; there is no combinational path from req_* to dm_*.
  - A reset mid-operation aborts immediately: no further dm_ access, no resp_valid. Bytes already written remain written.
- Request acceptance (cycle N):
  - Capture addr, wdata, Funct3 and the operation.
  - MemRead && MemWrite is treated as a store.
  - Neither flag set means no memory access: resp_valid at N+1 with rd=0.
- States:
  - IDLE
  - LD_LO: dm_MemRead=1, dm_Funct3=LW, dm_a={addr[8:2],2'b00}. Capture dm_rd into lo.
  - LD_HI: only if the load crosses a word. dm_a = next word, modulo 2^DM_ADDRESS, so 0x1FC wraps to 0x000. Capture dm_rd into hi.
  - ST_SEQ: one write per cycle.
  - RESP: resp_valid=1, req_ready=0. Next state is IDLE.
- Load size is 1 byte for LB/LBU, 2 for LH/LHU, 4 for LW and unsupported funct3 (011/110/111).
  - The load crosses a word when addr[1:0]+size > 4.
  - Result: {hi,lo} >> (8*addr[1:0]), truncated to size.
  - Sign-extended for LB/LH/LW; zero-extended for LBU (100) and LHU (101).
- Load latency: aligned or non-crossing resp at N+2; crossing resp at N+3.
- Stores:
  - SW with addr[1:0]=0: a single write with dm_Funct3=SW, dm_wd=wdata.
  - SW misaligned: 4 SB writes.
  - SH (any alignment): 2 SB writes.
  - SB: 1 SB write.
  - Unsupported funct3 is treated as SW.
- Byte write k (k=0..size-1):
  - dm_a = addr+k, with wrap.
  - dm_Funct3 = SB.
  - dm_wd = wdata byte k placed at lane (addr+k)[1:0].
  - Bytes are written in ascending address order.
- Store latency: k writes in N+1..N+k, resp_valid at N+k+1.
- rd=0 on store responses.
- req_ready is high only in IDLE.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a misaligned request raises misalign_err=1 with resp_valid at N+1 and makes no dm_ access.
  - Misaligned means: LH/LHU/SH with addr[0]=1; LW/SW or unsupported funct3 with addr[1:0]≠0.
  - Aligned requests behave as without the macro.
- Undefined: misalign_err is tied to 0 and misaligned accesses are split as described in Behaviour.

Test Plan:
- Preload word 0x010=0x44332211, word 0x014=0x88776655. LW addr=0x012 → LD_LO 0x010, LD_HI 0x014, rd=0x66554433, resp_valid at N+3.
- LH addr=0x013 → rd=0x00005544 at N+3. LB addr=0x017 → rd=0xFFFFFF88 at N+2. LBU addr=0x017 → rd=0x00000088.
- SW wdata=0xAABBCCDD, addr=0x01F → 4 SB writes (0x1F=DD, 0x20=CC, 0x21=BB, 0x22=AA) in N+1..N+4, resp at N+5. LW at 0x020 then returns 0x??AABBCC with the upper byte unchanged.
- LW addr=0x1FE with word 0x1FC=0xDDCC0000, word 0x000=0x0000BBAA → second read at dm_a=0x000, rd=0xBBAADDCC.
- Assert reset after the 2nd SB of a misaligned SW → dm_MemWrite=0 next cycle, req_ready=1, no resp_valid, only 2 bytes modified.
- With MISALIGN_TRAP_EN defined: SH addr=0x005 → resp_valid and misalign_err at N+1, no dm_MemWrite. SW addr=0x008 → normal SW, misalign_err=0.
